// File: rtl/adc_capture_pkg.sv
// Shared encodings for the ADC frame-capture sequencer.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } cap_state_e;

  localparam logic [1:0] TRIG_IMM   = 2'd0;
  localparam logic [1:0] TRIG_EXT   = 2'd1;
  localparam logic [1:0] TRIG_LEVEL = 2'd2;
  localparam logic [1:0] TRIG_RSVD  = 2'd3;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// AXI-Stream link from the capture sequencer to the DMA side.
interface adc_capture_ctrl_if #(
  parameter int DATA_WIDTH = 12
) ();
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/adc_trig_detect.sv
// Trigger source mux; the level mode fires on an upward crossing of the threshold.
module adc_trig_detect
  import adc_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm_i,
  input  logic                  active_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] level_i,
  input  logic                  ext_trig_i,
  input  logic                  adc_valid_i,
  input  logic [DATA_WIDTH-1:0] adc_data_i,
  output logic                  trig_hit_o
);

  logic [DATA_WIDTH-1:0] prev_q;
  logic                  seeded_q;

  // The first sample after arming only seeds history so a frame never starts
  // on an unknown prior value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q   <= '0;
      seeded_q <= 1'b0;
    end else if (arm_i) begin
      prev_q   <= '0;
      seeded_q <= 1'b0;
    end else if (active_i && adc_valid_i) begin
      prev_q   <= adc_data_i;
      seeded_q <= 1'b1;
    end
  end

  always_comb begin
    trig_hit_o = 1'b0;
    if (active_i) begin
      case (mode_i)
        TRIG_EXT:   trig_hit_o = ext_trig_i;
        TRIG_LEVEL: trig_hit_o = adc_valid_i && seeded_q &&
                                 (prev_q < level_i) && (adc_data_i >= level_i);
        default:    trig_hit_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Frame-capture sequencer: arm, wait for trigger, stream cfg_frame_len decimated samples.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [1:0]            cfg_trig_mode,
  input  logic [DATA_WIDTH-1:0] cfg_trig_level,
  input  logic [REG_WIDTH-1:0]  cfg_frame_len,
  input  logic [REG_WIDTH-1:0]  cfg_decimate,
  input  logic                  ext_trig,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  dec_run,
  output logic [REG_WIDTH-1:0]  dec_ratio,
  input  logic                  dec_valid,
  input  logic [DATA_WIDTH-1:0] dec_data,
  adc_capture_ctrl_if.master    m_axis,
  output logic                  sts_busy,
  output logic [1:0]            sts_state,
  output logic [REG_WIDTH-1:0]  sts_count,
  output logic                  sts_overflow,
  output logic                  irq_done
);

  cap_state_e            state_q;
  logic                  dec_run_q;
  logic [REG_WIDTH-1:0]  ratio_q;
  logic [REG_WIDTH-1:0]  len_q;
  logic [1:0]            mode_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [REG_WIDTH-1:0]  count_q;
  logic                  ovf_q;
  logic                  irq_q;

  logic arm;
  logic trig_hit;
  logic last_beat;
  logic beat_taken;

  assign arm        = (state_q == ST_IDLE) && cfg_start && !cfg_abort;
  assign last_beat  = (count_q == len_q - REG_WIDTH'(1));
  assign beat_taken = tvalid_q && m_axis.tready;

  adc_trig_detect #(.DATA_WIDTH(DATA_WIDTH)) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm_i      (arm),
    .active_i   (state_q == ST_ARMED),
    .mode_i     (mode_q),
    .level_i    (cfg_trig_level),
    .ext_trig_i (ext_trig),
    .adc_valid_i(adc_valid),
    .adc_data_i (adc_data),
    .trig_hit_o (trig_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dec_run_q <= 1'b0;
      ratio_q   <= '0;
      len_q     <= REG_WIDTH'(1);
      mode_q    <= TRIG_IMM;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (cfg_abort) begin
        // Pending beat is discarded; the DMA side never sees a partial tlast.
        state_q   <= ST_IDLE;
        dec_run_q <= 1'b0;
        tvalid_q  <= 1'b0;
        tlast_q   <= 1'b0;
      end else begin
        if (beat_taken) begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
        end
        case (state_q)
          ST_IDLE: begin
            if (cfg_start) begin
              state_q <= ST_ARMED;
              ratio_q <= cfg_decimate;
              len_q   <= (cfg_frame_len == '0) ? REG_WIDTH'(1) : cfg_frame_len;
              mode_q  <= cfg_trig_mode;
              count_q <= '0;
              ovf_q   <= 1'b0;
            end
          end
          ST_ARMED: begin
            if (trig_hit) begin
              state_q   <= ST_CAPTURE;
              dec_run_q <= 1'b1;
            end
          end
          ST_CAPTURE: begin
            if (dec_valid) begin
              if (!tvalid_q || m_axis.tready) begin
                tdata_q  <= dec_data;
                tvalid_q <= 1'b1;
                tlast_q  <= last_beat;
                count_q  <= count_q + REG_WIDTH'(1);
                if (last_beat) begin
                  state_q   <= ST_DRAIN;
                  dec_run_q <= 1'b0;
                end
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (beat_taken && tlast_q) begin
              irq_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dec_run       = dec_run_q;
  assign dec_ratio     = ratio_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign sts_busy      = (state_q != ST_IDLE);
  assign sts_state     = state_q;
  assign sts_count     = count_q;
  assign sts_overflow  = ovf_q;
  assign irq_done      = irq_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: vector table plus corner-case sequences.
module tb_adc_capture_ctrl;

  localparam int DW = 12;
  localparam int RW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start, cfg_abort;
  logic [1:0]    cfg_trig_mode;
  logic [DW-1:0] cfg_trig_level;
  logic [RW-1:0] cfg_frame_len, cfg_decimate;
  logic          ext_trig, adc_valid;
  logic [DW-1:0] adc_data;
  logic          dec_run;
  logic [RW-1:0] dec_ratio;
  logic          dec_valid;
  logic [DW-1:0] dec_data;
  logic          sts_busy;
  logic [1:0]    sts_state;
  logic [RW-1:0] sts_count;
  logic          sts_overflow, irq_done;

  int checks   = 0;
  int failures = 0;

  adc_capture_ctrl_if #(.DATA_WIDTH(DW)) axis ();

  adc_capture_ctrl #(.DATA_WIDTH(DW), .REG_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_trig_mode(cfg_trig_mode), .cfg_trig_level(cfg_trig_level),
    .cfg_frame_len(cfg_frame_len), .cfg_decimate(cfg_decimate),
    .ext_trig(ext_trig), .adc_valid(adc_valid), .adc_data(adc_data),
    .dec_run(dec_run), .dec_ratio(dec_ratio),
    .dec_valid(dec_valid), .dec_data(dec_data),
    .m_axis(axis),
    .sts_busy(sts_busy), .sts_state(sts_state), .sts_count(sts_count),
    .sts_overflow(sts_overflow), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic          start;
    logic          dv;
    logic [DW-1:0] dd;
    logic          tready;
    logic [1:0]    e_state;
    logic          e_run;
    logic          e_tvalid;
    logic [DW-1:0] e_tdata;
    logic          e_tlast;
    logic [RW-1:0] e_count;
    logic          e_irq;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // state, dec_run, tvalid, tdata (only meaningful while tvalid), tlast, count, irq
  function automatic logic [63:0] snap();
    logic [DW-1:0] td;
    td = axis.tvalid ? axis.tdata : '0;
    return {sts_state, dec_run, axis.tvalid, td, axis.tlast, sts_count, irq_done};
  endfunction

  function automatic logic [63:0] vexp(input vec_t v);
    return {v.e_state, v.e_run, v.e_tvalid, v.e_tdata, v.e_tlast, v.e_count, v.e_irq};
  endfunction

  // Streams n samples back to back with tready high, then checks completion.
  task automatic run_frame(input string name, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      dec_valid = 1'b1;
      dec_data  = DW'(base + i);
      axis.tready = 1'b1;
      tick();
      chk(name, {axis.tvalid, axis.tdata, axis.tlast, sts_count},
          {1'b1, DW'(base + i), (i == n - 1), RW'(i + 1)});
    end
    dec_valid = 1'b0;
    tick();
    chk({name, "_irq"}, {irq_done, sts_state, axis.tvalid}, {1'b1, 2'd0, 1'b0});
    tick();
    chk({name, "_irq_pulse"}, {irq_done, sts_state}, {1'b0, 2'd0});
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_trig_mode = 2'd0; cfg_trig_level = '0;
    cfg_frame_len = 32'd4; cfg_decimate = 32'd9;
    ext_trig = 1'b0; adc_valid = 1'b0; adc_data = '0;
    dec_valid = 1'b0; dec_data = '0; axis.tready = 1'b0;

    tick(); tick();
    chk("reset", {snap(), dec_ratio[7:0], sts_overflow, sts_busy}, '0);
    rst_n = 1'b1;
    tick();

    // Mode 0, len 4, ratio 9, tready always high.
    vecs[0] = '{1'b1, 1'b0, 12'd0,  1'b1, 2'd1, 1'b0, 1'b0, 12'd0,  1'b0, 32'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 12'd0,  1'b1, 2'd2, 1'b1, 1'b0, 12'd0,  1'b0, 32'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 12'd10, 1'b1, 2'd2, 1'b1, 1'b1, 12'd10, 1'b0, 32'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 12'd20, 1'b1, 2'd2, 1'b1, 1'b1, 12'd20, 1'b0, 32'd2, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 12'd30, 1'b1, 2'd2, 1'b1, 1'b1, 12'd30, 1'b0, 32'd3, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 12'd40, 1'b1, 2'd3, 1'b0, 1'b1, 12'd40, 1'b1, 32'd4, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 12'd0,  1'b1, 2'd0, 1'b0, 1'b0, 12'd0,  1'b0, 32'd4, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 12'd0,  1'b1, 2'd0, 1'b0, 1'b0, 12'd0,  1'b0, 32'd4, 1'b0};
    for (int i = 0; i < 8; i++) begin
      cfg_start   = vecs[i].start;
      dec_valid   = vecs[i].dv;
      dec_data    = vecs[i].dd;
      axis.tready = vecs[i].tready;
      tick();
      chk($sformatf("vec%0d", i), snap(), vexp(vecs[i]));
    end
    chk("ratio_latched", dec_ratio, 32'd9);
    cfg_start = 1'b0; dec_valid = 1'b0;

    // Level trigger: upward ramp crosses at 0x800.
    cfg_trig_mode = 2'd2; cfg_trig_level = 12'h800;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    adc_valid = 1'b1;
    adc_data = 12'h7F0; tick(); chk("lvl_seed", sts_state, 2'd1);
    adc_data = 12'h7F8; tick(); chk("lvl_below", sts_state, 2'd1);
    adc_data = 12'h800; tick(); chk("lvl_cross", sts_state, 2'd2);
    adc_valid = 1'b0;
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    // Starting above threshold must first drop below before firing.
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    adc_valid = 1'b1;
    adc_data = 12'h900; tick(); chk("lvl_hi_seed", sts_state, 2'd1);
    adc_data = 12'h910; tick(); chk("lvl_hi_stay", sts_state, 2'd1);
    adc_data = 12'h700; tick(); chk("lvl_drop", sts_state, 2'd1);
    adc_data = 12'h800; tick(); chk("lvl_recross", sts_state, 2'd2);
    adc_valid = 1'b0;
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;

    // Backpressure: first beat held, next two dropped.
    cfg_trig_mode = 2'd0; cfg_frame_len = 32'd3;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("ovf_cleared", sts_overflow, 1'b0);
    tick();
    axis.tready = 1'b0;
    dec_valid = 1'b1; dec_data = 12'h111; tick();
    dec_data = 12'h222; tick();
    chk("bp_hold1", {axis.tvalid, axis.tdata, sts_count[7:0], sts_overflow},
        {1'b1, 12'h111, 8'd1, 1'b1});
    dec_data = 12'h333; tick();
    dec_valid = 1'b0;
    chk("bp_hold2", {axis.tvalid, axis.tdata, axis.tlast, sts_count[7:0], sts_overflow},
        {1'b1, 12'h111, 1'b0, 8'd1, 1'b1});
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;

    // Abort mid-frame with a beat pending, then a clean 8-beat restart.
    cfg_frame_len = 32'd8;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    tick();
    axis.tready = 1'b1;
    dec_valid = 1'b1; dec_data = 12'd1; tick();
    dec_data = 12'd2; tick();
    dec_valid = 1'b0; axis.tready = 1'b0;
    chk("abort_pre", {sts_state, axis.tvalid, sts_count[7:0]}, {2'd2, 1'b1, 8'd2});
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    chk("abort", {sts_state, axis.tvalid, axis.tlast, dec_run, irq_done},
        {2'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    tick();
    chk("abort_noirq", {irq_done, sts_busy}, 2'b00);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    tick();
    run_frame("restart8", 8, 100);

    // Zero length means one beat; ratio shadowed across the frame.
    cfg_frame_len = 32'd0; cfg_decimate = 32'd3;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    cfg_decimate = 32'd77;
    tick();
    axis.tready = 1'b0;
    dec_valid = 1'b1; dec_data = 12'h5A5; tick(); dec_valid = 1'b0;
    chk("len0_beat", {sts_state, axis.tvalid, axis.tdata, axis.tlast, sts_count[7:0]},
        {2'd3, 1'b1, 12'h5A5, 1'b1, 8'd1});
    chk("ratio_shadow", dec_ratio, 32'd3);
    axis.tready = 1'b1; tick();
    chk("len0_irq", {irq_done, sts_state}, {1'b1, 2'd0});
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("ratio_new", dec_ratio, 32'd77);
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;

    // Reset in CAPTURE with a beat pending and overflow set.
    cfg_frame_len = 32'd4;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    tick();
    axis.tready = 1'b0;
    dec_valid = 1'b1; dec_data = 12'h0AB; tick(); tick();
    dec_valid = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_capture", {snap(), dec_ratio[7:0], sts_overflow, sts_busy}, '0);
    // Start and abort together in IDLE: abort wins.
    cfg_start = 1'b1; cfg_abort = 1'b1; tick(); cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("start_abort", {sts_state, sts_busy}, 3'b000);
    tick();
    chk("start_abort_idle", {sts_state, dec_run}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
